// File: rtl/right_shift_pipelined_stall.sv
// Pipelined right shifter with valid/ready flow control. Each stage resolves one
// radix-4 digit of the shift amount, most significant digit first.
module right_shift_pipelined_stall #(
  parameter int WIDTH  = 13,
  parameter int STAGES = ($clog2(WIDTH) + 1) / 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         i_in,
  input  logic [$clog2(WIDTH)-1:0] i_shift,
  input  logic                     i_arith,
  input  logic                     i_validIn,
  output logic                     o_readyIn,
  output logic [WIDTH-1:0]         o_out,
  output logic                     o_validOut,
  input  logic                     i_readyOut
);

  localparam int SPW = 2 * STAGES;

  // One stage: a 4:1 mux per bit choosing a shift of 0..3 units of 4^stage,
  // pulling the fill bit in above the MSB.
  function automatic logic [WIDTH-1:0] applyDigit(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       digit,
    input logic             fill,
    input int               stage
  );
    logic [WIDTH-1:0]   cand [4];
    logic [2*WIDTH-1:0] ext;
    int                 unit;
    unit = 1 << (2 * stage);
    ext  = {{WIDTH{fill}}, d};
    for (int k = 0; k < 4; k++) begin
      if (k * unit >= WIDTH) cand[k] = {WIDTH{fill}};
      else                   cand[k] = WIDTH'(ext >> (k * unit));
    end
    return cand[digit];
  endfunction

  logic [WIDTH-1:0] r_data  [STAGES];
  logic [SPW-1:0]   r_shift [STAGES];
  logic [STAGES-1:0] r_fill;
  logic [STAGES-1:0] r_valid;

  logic [WIDTH-1:0] w_nextData [STAGES];
  logic [SPW-1:0]   w_shiftIn;
  logic             w_fillIn;
  logic             w_adv;
  logic             w_unusedTail;

  // Shift amount is zero-padded to a whole number of radix-4 digits.
  assign w_shiftIn = SPW'(i_shift);
  assign w_fillIn  = i_arith & i_in[WIDTH-1];
  assign w_adv     = ~r_valid[0] | i_readyOut;

  assign o_readyIn  = w_adv;
  assign o_out      = r_data[0];
  assign o_validOut = r_valid[0];

  // Stage 0's shift and fill entries have no downstream consumer.
  assign w_unusedTail = r_fill[0] ^ (^r_shift[0]);

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_nextData[s] = '0;
    end
    w_nextData[STAGES-1] = applyDigit(i_in, w_shiftIn[2*(STAGES-1) +: 2],
                                      w_fillIn, STAGES - 1);
    for (int s = 0; s < STAGES - 1; s++) begin
      w_nextData[s] = applyDigit(r_data[s+1], r_shift[s+1][2*s +: 2],
                                 r_fill[s+1], s);
    end
  end

  // The whole pipeline moves together or holds together.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        r_data[s]  <= '0;
        r_shift[s] <= '0;
      end
      r_fill  <= '0;
      r_valid <= '0;
    end else if (w_adv) begin
      r_data[STAGES-1]  <= w_nextData[STAGES-1];
      r_shift[STAGES-1] <= w_shiftIn;
      r_fill[STAGES-1]  <= w_fillIn;
      r_valid[STAGES-1] <= i_validIn;
      for (int s = 0; s < STAGES - 1; s++) begin
        r_data[s]  <= w_nextData[s];
        r_shift[s] <= r_shift[s+1];
        r_fill[s]  <= r_fill[s+1];
        r_valid[s] <= r_valid[s+1];
      end
    end
  end

endmodule

// File: tb/tb_right_shift_pipelined_stall.sv
// Scoreboard bench for right_shift_pipelined_stall: a driver pushes expected
// results on each accepted input, a monitor pops them on each output transfer.
module tb_right_shift_pipelined_stall;

  localparam int W  = 13;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  i_in;
  logic [SW-1:0] i_shift;
  logic          i_arith;
  logic          i_validIn;
  logic          o_readyIn;
  logic [W-1:0]  o_out;
  logic          o_validOut;
  logic          i_readyOut;

  typedef struct {
    logic [W-1:0] data;
    int           acceptCycle;
    bit           chkLat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cycleCnt = 0;
  int   sinkMode = 2;

  right_shift_pipelined_stall dut (
    .clk        (clk),
    .reset      (reset),
    .i_in       (i_in),
    .i_shift    (i_shift),
    .i_arith    (i_arith),
    .i_validIn  (i_validIn),
    .o_readyIn  (o_readyIn),
    .o_out      (o_out),
    .o_validOut (o_validOut),
    .i_readyOut (i_readyOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Reference: a plain shift of the whole word, sign-extending when arithmetic.
  function automatic logic [W-1:0] refShift(input logic [W-1:0] d, input int unsigned sh,
                                            input bit ar);
    if (ar) return W'($signed(d) >>> sh);
    return d >> sh;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  // Presents one item and holds it until accepted; records the expected result.
  task automatic applyStimulus(input logic [W-1:0] d, input logic [SW-1:0] sh, input bit ar,
                               input bit chkLat, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    i_in = d; i_shift = sh; i_arith = ar; i_validIn = 1'b1;
    #1;
    while (!o_readyIn && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (o_readyIn) begin
      e.data = refShift(d, sh, ar);
      e.acceptCycle = cycleCnt;
      e.chkLat = chkLat;
      sb.push_back(e);
    end else begin
      total++; bad++;
      $display("[TB] FAIL acceptTimeout: readyIn stayed %0b, required 1", o_readyIn);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      i_validIn = 1'b0;
      i_in = W'($urandom);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      i_validIn = 1'b0;
      #1;
      n++;
    end while (sb.size() > 0 && n < 200);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("[TB] FAIL drainTimeout: %0d results outstanding, required 0", sb.size());
    end
    idleCycles(3);
  endtask

  // Sink: 0 = always ready, 1 = random backpressure, 2 = stalled.
  initial begin
    forever begin
      @(negedge clk);
      case (sinkMode)
        0:       i_readyOut = 1'b1;
        1:       i_readyOut = 1'($urandom_range(0, 1));
        default: i_readyOut = 1'b0;
      endcase
    end
  end

  // Monitor: every output transfer must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && o_validOut && i_readyOut) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpectedOutput: got %h, required no transfer", o_out);
        end else begin
          e = sb.pop_front();
          checkOutput("outData", 32'(o_out), 32'(e.data));
          if (e.chkLat) checkOutput("latency", 32'(cycleCnt - e.acceptCycle), 32'd2);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d results outstanding", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    logic [W-1:0] expA;
    reset = 1'b1;
    i_in = 13'h0AAA; i_shift = 4'd3; i_arith = 1'b1; i_validIn = 1'b1;
    i_readyOut = 1'b0;
    sinkMode = 2;

    // Reset state, with a valid input offered that must be ignored.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetValidOut", 32'(o_validOut), 32'd0);
    checkOutput("resetOut", 32'(o_out), 32'd0);
    checkOutput("resetReadyIn", 32'(o_readyIn), 32'd1);
    sinkMode = 0;
    @(posedge clk);
    #2 reset = 1'b0;

    // Directed cases; the first is offered in the first cycle after reset.
    applyStimulus(13'h1F00, 4'd4, 1'b0, 1'b1, waited);
    checkOutput("firstAccept", 32'(waited), 32'd0);
    applyStimulus(13'h1F00, 4'd4, 1'b1, 1'b1, waited);
    applyStimulus(13'h1000, 4'd15, 1'b1, 1'b1, waited);
    applyStimulus(13'h1000, 4'd15, 1'b0, 1'b1, waited);
    applyStimulus(13'h0ABC, 4'd13, 1'b1, 1'b1, waited);
    applyStimulus(13'h1ABC, 4'd12, 1'b1, 1'b1, waited);
    drain();

    // Back-to-back stream over every shift amount.
    for (int sh = 0; sh < 16; sh++) begin
      applyStimulus(13'h1555, SW'(sh), 1'b1, 1'b1, waited);
      checkOutput("streamAccept", 32'(waited), 32'd0);
    end
    drain();

    // Stall with output pending: everything must hold and no input may enter.
    sinkMode = 2;
    expA = refShift(13'h1234, 5, 1'b1);
    applyStimulus(13'h1234, 4'd5, 1'b1, 1'b0, waited);
    applyStimulus(13'h0F0F, 4'd2, 1'b0, 1'b0, waited);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_in = 13'h1FFF; i_shift = 4'd1; i_arith = 1'b1; i_validIn = 1'b1;
      #1;
      checkOutput("stallOut", 32'(o_out), 32'(expA));
      checkOutput("stallValid", 32'(o_validOut), 32'd1);
      checkOutput("stallReadyIn", 32'(o_readyIn), 32'd0);
    end
    sinkMode = 0;
    applyStimulus(13'h1FFF, 4'd1, 1'b1, 1'b0, waited);
    drain();

    // Randomized traffic with bubbles and random backpressure.
    sinkMode = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idleCycles(1);
      applyStimulus(W'($urandom), SW'($urandom), 1'($urandom), 1'b0, waited);
    end
    sinkMode = 0;
    drain();

    // Reset with two items in flight: both must vanish.
    sinkMode = 2;
    applyStimulus(13'h1111, 4'd1, 1'b0, 1'b0, waited);
    applyStimulus(13'h1222, 4'd2, 1'b1, 1'b0, waited);
    @(negedge clk);
    reset = 1'b1;
    i_validIn = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    sinkMode = 0;
    sb.delete();
    applyStimulus(13'h1C3A, 4'd6, 1'b1, 1'b1, waited);
    checkOutput("acceptAfterReset", 32'(waited), 32'd0);
    checkOutput("validAfterReset", 32'(o_validOut), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/right_shift_pipelined_stall.md
RIGHT_SHIFT_PIPELINED_STALL -- requirements
Module: rightShiftPipelinedStall

Interface
REQ-001 Parameter WIDTH, default 13, SHALL give the data width in bits.
REQ-002 Parameter STAGES, default ($clog2(WIDTH)+1)/2, SHALL give the pipeline depth; each stage resolves one radix-4 digit of the shift.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in  input  WIDTH  SHALL carry the operand.
REQ-006 shift  input  $clog2(WIDTH)  SHALL carry the right-shift amount (unsigned).
REQ-007 arith  input  1  SHALL select the fill value: 1 = arithmetic (in[WIDTH-1]), 0 = logical (zeros).
REQ-008 validIn  input  1  SHALL qualify in/shift/arith.
REQ-009 readyIn  output  1  SHALL indicate the block accepts an input this cycle.
REQ-010 out  output  WIDTH  SHALL carry the shifted result.
REQ-011 validOut  output  1  SHALL qualify out.
REQ-012 readyOut  input  1  SHALL indicate the downstream consumer accepts out this cycle.

Function
REQ-013 The block SHALL compute out = in >> shift with vacated MSBs filled by the fill bit; shift >= WIDTH SHALL yield all-fill.
REQ-014 Stage numbering: input stage STAGES-1 SHALL apply digit shift[2(STAGES-1)+1 : 2(STAGES-1)] x 4^(STAGES-1); stage s SHALL apply digit s x 4^s; stage 0 drives out.
REQ-015 Each stage SHALL be a 4:1 mux per bit (shift by 0, 1, 2 or 3 x 4^s); source bits above WIDTH-1 SHALL be the fill bit.
REQ-016 When $clog2(WIDTH) is odd, the missing top shift bit SHALL be treated as 0.
REQ-017 The fill bit and remaining shift bits SHALL travel with the data through registered side pipelines, one entry per stage.
REQ-018 Pipeline advance enable adv = ~validOut | readyOut; readyIn SHALL equal adv combinationally.
REQ-019 When adv=1 every stage (data, shift, fill, valid) SHALL load from its predecessor, the input stage from the ports; an input transfers iff validIn & readyIn.
REQ-020 When adv=0 all stage registers SHALL hold; out and validOut SHALL remain stable until readyOut=1.
REQ-021 Latency SHALL be exactly STAGES cycles from an accepted input to validOut, absent stalls; throughput one result per cycle with readyOut held 1.
REQ-022 Bubbles (validIn=0 while adv=1) SHALL propagate as validOut=0 slots; data contents of invalid slots are don't-care.
REQ-023 An output transfers iff validOut & readyOut; each accepted input SHALL produce exactly one output transfer, in order, none dropped or duplicated.
REQ-024 Simultaneous output transfer and input acceptance in one cycle SHALL be supported without a bubble.

Reset
REQ-025 While reset=1 all valid bits, data, shift and fill registers SHALL clear to 0: validOut=0, out=0, readyIn=1.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight items; no output for them after reset deasserts.
REQ-027 An input presented with validIn=1 in a reset cycle SHALL NOT be accepted.
REQ-028 The first input SHALL be acceptable in the first cycle after reset deasserts.

Verification (WIDTH=13, STAGES=2)
REQ-029 in=13'h1F00, shift=4, arith=0, readyOut=1 -> out=13'h01F0, validOut=1 exactly 2 cycles after acceptance.
REQ-030 in=13'h1F00, shift=4, arith=1 -> out=13'h1FF0; in=13'h1000, shift=15, arith=1 -> 13'h1FFF; same with arith=0 -> 13'h0000.
REQ-031 Back-to-back stream, shift=0..15 on consecutive cycles, in=13'h1555, arith=1 -> 16 consecutive validOut=1 results matching a reference model, in order.
REQ-032 readyOut=0 for 5 cycles with a valid output pending -> out/validOut constant, readyIn=0, no input accepted; on readyOut=1 stream resumes with no loss or duplication.
REQ-033 reset pulsed for 1 cycle with 2 items in flight -> validOut=0 from next cycle, no stale result ever emitted, new item accepted immediately after.
